// File: rtl/elbert_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// elbert_pkg
// Shared constants and helpers for the Elbert v2 input conditioner.
//   CLK_HZ                  - board oscillator frequency (12 MHz)
//   DEFAULT_DEBOUNCE_CYCLES - qualifying ticks used when no override is given
//   clog2()                 - constant ceil(log2(n)), never below 1, for sizing
// -----------------------------------------------------------------------------
package elbert_pkg;

    localparam int CLK_HZ                  = 12_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Minimum of 1 so a 1-state counter still gets a legal 1-bit vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/elbert_input_conditioner_if.sv
// -----------------------------------------------------------------------------
// elbert_input_conditioner_if
// Bundles the per-channel signals between user logic and the conditioner.
//   tick        - debounce sample enable (master -> slave)
//   raw_in      - raw pin levels, asynchronous (master -> slave)
//   toggle_clr  - per-channel synchronous clear of toggle_out (master -> slave)
//   level_out   - debounced, polarity-corrected level (slave -> master)
//   rise_out    - one-cycle pulse on a 0->1 change of level_out
//   fall_out    - one-cycle pulse on a 1->0 change of level_out
//   toggle_out  - flips on every rise
// The conditioner itself uses the slave modport.
// -----------------------------------------------------------------------------
interface elbert_input_conditioner_if #(
    parameter int WIDTH = 8
) ();

    logic             tick;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] toggle_clr;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] rise_out;
    logic [WIDTH-1:0] fall_out;
    logic [WIDTH-1:0] toggle_out;

    modport master (
        output tick,
        output raw_in,
        output toggle_clr,
        input  level_out,
        input  rise_out,
        input  fall_out,
        input  toggle_out
    );

    modport slave (
        input  tick,
        input  raw_in,
        input  toggle_clr,
        output level_out,
        output rise_out,
        output fall_out,
        output toggle_out
    );

endinterface

// File: rtl/elbert_input_conditioner_debounce_ch.sv
// -----------------------------------------------------------------------------
// elbert_debounce_ch
// One conditioning channel: 2-flop synchroniser, tick-qualified counter
// debounce, registered edge pulses and a toggle latch.
//   clk          - system clock
//   rst_n        - synchronous active-low reset
//   tick_i       - debounce sample enable
//   inv_i        - polarity-corrected raw input (asynchronous)
//   toggle_clr_i - clears toggle_o at the next edge; beats a coincident rise
//   level_o      - debounced level
//   rise_o       - one-cycle pulse on the edge level_o goes 0->1
//   fall_o       - one-cycle pulse on the edge level_o goes 1->0
//   toggle_o     - flips on each rise
// -----------------------------------------------------------------------------
module elbert_debounce_ch
    import elbert_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic inv_i,
    input  logic toggle_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic toggle_o
);

    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             toggle_q, toggle_d;

    // Counter only advances on ticks while the input disagrees with the
    // accepted level; any agreeing cycle (tick or not) throws away progress,
    // which is what rejects short glitches.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (toggle_clr_i) begin
            toggle_d = 1'b0;
        end else if (rise_d) begin
            toggle_d = ~toggle_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync1_q  <= inv_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign toggle_o = toggle_q;

endmodule

// File: rtl/elbert_input_conditioner.sv
// -----------------------------------------------------------------------------
// elbert_input_conditioner
// WIDTH independent input-conditioning channels for the Elbert v2 switches
// and buttons. Each raw pin is optionally inverted (INVERT_MASK bit = 1 for
// active-low buttons), then synchronised, debounced and edge-detected.
//   clk   - system clock (12 MHz on the board)
//   rst_n - synchronous active-low reset
//   bus   - elbert_input_conditioner_if slave: tick, raw_in, toggle_clr in;
//           level_out, rise_out, fall_out, toggle_out out
// -----------------------------------------------------------------------------
module elbert_input_conditioner
    import elbert_pkg::*;
#(
    parameter int               WIDTH           = 8,
    parameter int               DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] INVERT_MASK     = {WIDTH{1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst_n,
    elbert_input_conditioner_if.slave     bus
);

    logic [WIDTH-1:0] inv;
    logic [WIDTH-1:0] level_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [WIDTH-1:0] toggle_w;

    // Inversion sits in front of the synchroniser so an inverted pin idling
    // at its inactive level looks like 0 and matches the reset level.
    assign inv = bus.raw_in ^ INVERT_MASK;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
            elbert_debounce_ch #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .tick_i       (bus.tick),
                .inv_i        (inv[gi]),
                .toggle_clr_i (bus.toggle_clr[gi]),
                .level_o      (level_w[gi]),
                .rise_o       (rise_w[gi]),
                .fall_o       (fall_w[gi]),
                .toggle_o     (toggle_w[gi])
            );
        end
    endgenerate

    assign bus.level_out  = level_w;
    assign bus.rise_out   = rise_w;
    assign bus.fall_out   = fall_w;
    assign bus.toggle_out = toggle_w;

endmodule

// File: tb/tb_elbert_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_elbert_input_conditioner
// Directed bench: WIDTH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b0011.
// Inputs change on the falling edge; outputs are read on the falling edge
// after each rising edge k (k=1 is the first edge that sees a new input).
// -----------------------------------------------------------------------------
module tb_elbert_input_conditioner;

    localparam int         WIDTH = 4;
    localparam int         DEB   = 4;
    localparam logic [3:0] INV   = 4'b0011;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    elbert_input_conditioner_if #(.WIDTH(WIDTH)) bus ();

    elbert_input_conditioner #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB),
        .INVERT_MASK     (INV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", tag, $time, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n          = 1'b0;
        bus.tick       = 1'b1;
        bus.raw_in     = 4'b0011;   // inverted buttons idle high
        bus.toggle_clr = 4'b0000;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("reset_level",  32'(bus.level_out),  32'h0);
        check_val("reset_pulses", 32'({bus.rise_out, bus.fall_out}), 32'h0);
        check_val("reset_toggle", 32'(bus.toggle_out), 32'h0);
        rst_n = 1'b1;

        // Idle: no spurious activity on any channel
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check_val("idle_outputs",
                      32'({bus.level_out, bus.rise_out, bus.fall_out, bus.toggle_out}), 32'h0);
        end
        $display("phase idle done checks=%0d", n_checks);

        // Channel 2 press: level/rise/toggle at edge 6
        bus.raw_in[2] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check_val("ch2_level",  32'(bus.level_out[2]), 32'(k >= 6));
            check_val("ch2_rise",   32'(bus.rise_out[2]),  32'(k == 6));
            check_val("ch2_fall",   32'(bus.fall_out[2]),  32'h0);
            check_val("ch2_toggle", 32'(bus.toggle_out[2]), 32'(k >= 6));
        end
        $display("phase ch2_press done checks=%0d", n_checks);

        // Channel 0 active-low glitch: 3 qualifying cycles only, rejected
        bus.raw_in[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check_val("ch0_glitch", 32'({bus.level_out[0], bus.rise_out[0], bus.fall_out[0]}), 32'h0);
            if (k == 3) bus.raw_in[0] = 1'b1;
        end
        $display("phase ch0_glitch done checks=%0d", n_checks);

        // Channel 0 press held 5 cycles: rise at edge 6, fall at edge 11
        bus.raw_in[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check_val("ch0_level",  32'(bus.level_out[0]),  32'(k >= 6 && k < 11));
            check_val("ch0_rise",   32'(bus.rise_out[0]),   32'(k == 6));
            check_val("ch0_fall",   32'(bus.fall_out[0]),   32'(k == 11));
            check_val("ch0_toggle", 32'(bus.toggle_out[0]), 32'(k >= 6));
            if (k == 5) bus.raw_in[0] = 1'b1;
        end
        $display("phase ch0_press done checks=%0d", n_checks);

        // Channel 3 with tick on edges 3,7,11,15: level changes at edge 15
        bus.raw_in[3] = 1'b1;
        bus.tick      = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            check_val("ch3_tick_level", 32'(bus.level_out), 32'({k >= 15, 3'b100}));
            check_val("ch3_tick_rise",  32'(bus.rise_out[3]), 32'(k == 15));
            bus.tick = ((k + 1) % 4 == 3);
        end
        bus.tick = 1'b1;
        $display("phase ch3_tick done checks=%0d", n_checks);

        // Channel 2 release then second press: toggle back to 0
        bus.raw_in[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check_val("ch2_rel_fall",  32'(bus.fall_out[2]),  32'h1);
                check_val("ch2_rel_level", 32'(bus.level_out[2]), 32'h0);
            end
        end
        bus.raw_in[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check_val("ch2_press2_rise",   32'(bus.rise_out[2]),   32'h1);
                check_val("ch2_press2_toggle", 32'(bus.toggle_out[2]), 32'h0);
            end
        end
        bus.raw_in[2] = 1'b0;
        repeat (10) @(negedge clk);

        // Third press with toggle_clr on the rise edge: clear wins
        bus.raw_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 6) begin
                check_val("ch2_clr_rise",   32'(bus.rise_out[2]),  32'h1);
                check_val("ch2_clr_level",  32'(bus.level_out[2]), 32'h1);
                check_val("ch2_clr_toggle", 32'(bus.toggle_out),   32'h9);
            end
            if (k == 7) begin
                check_val("ch2_clr_after", 32'({bus.toggle_out, bus.rise_out}), 32'h90);
            end
            bus.toggle_clr = (k == 5) ? 4'b0100 : 4'b0000;
        end
        $display("phase ch2_toggle done checks=%0d", n_checks);
        repeat (4) @(negedge clk);

        // Reset while channel 1 holds cnt=2; channels 1,2,3 requalify together
        bus.raw_in[1] = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check_val("rst_level",  32'(bus.level_out),
                      (k <= 4) ? 32'hC : ((k >= 11) ? 32'hE : 32'h0));
            check_val("rst_rise",   32'(bus.rise_out), (k == 11) ? 32'hE : 32'h0);
            check_val("rst_fall",   32'(bus.fall_out), 32'h0);
            check_val("rst_toggle", 32'(bus.toggle_out),
                      (k <= 4) ? 32'h9 : ((k >= 11) ? 32'hE : 32'h0));
            if (k == 4) rst_n = 1'b0;
            if (k == 5) rst_n = 1'b1;
        end
        $display("phase reset_mid done checks=%0d", n_checks);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elbert_input_conditioner.md
Name: elbert_input_conditioner

Overview:
- Parametrised, registered successor to the single-bit combinational inverter.
- Conditions WIDTH raw board inputs (DIP switches, push-buttons) per channel: optional inversion, 2-flop synchronisation, counter debounce, edge pulses, toggle latch.
- Sits between the board input pins and user logic or LED drivers on the Elbert v2 (12 MHz clock).

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- DEBOUNCE_CYCLES, 4, consecutive qualifying ticks with the input differing from the stable state before a change is accepted (>=1).
- INVERT_MASK, {WIDTH{1'b0}}, per-channel inversion; bit=1 inverts that raw input before synchronisation (active-low buttons).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  debounce sample enable; tie high for per-cycle debounce, or drive from a prescaler
- raw_in  in  WIDTH  asynchronous pin inputs
- toggle_clr  in  WIDTH  per-channel synchronous clear of toggle_out
- level_out  out  WIDTH  debounced, polarity-corrected level
- rise_out  out  WIDTH  one-cycle pulse on a 0->1 change of level_out
- fall_out  out  WIDTH  one-cycle pulse on a 1->0 change of level_out
- toggle_out  out  WIDTH  flips on each rise

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset is synchronous and active-low on rst_n.
  - While rst_n=0 at a clk edge: sync flops, counters, level_out, rise_out, fall_out and toggle_out all go to 0.
- Inversion: inv = raw_in ^ INVERT_MASK, purely combinational ahead of sync stage 1.
- Synchroniser:
  - 2 flops per channel, clocked every cycle regardless of tick.
  - sync2 reflects inv two edges after inv changes.
- Debounce, per channel. Counter width CNT_W = clog2(DEBOUNCE_CYCLES+1).
  - sync2 == level: cnt <= 0 every cycle, whether or not tick is high.
  - sync2 != level and tick=1 and cnt == DEBOUNCE_CYCLES-1: level <= sync2, cnt <= 0.
  - sync2 != level and tick=1 otherwise: cnt <= cnt+1.
  - sync2 != level and tick=0: cnt holds.
  - Any single cycle where sync2 matches level restarts qualification (glitch rejection).
- Latency, tick tied high: raw change -> level_out change on clk edge 2+DEBOUNCE_CYCLES after the first edge that samples the change.
- Edge pulses:
  - rise_out/fall_out are registered and assert on the same edge level_out changes.
  - Each is high exactly one cycle; never both high on a channel.
- Toggle:
  - toggle_out updates on the same edge as rise_out asserts.
  - toggle_clr=1 forces toggle_out <= 0 at the next edge.
  - clr and rise on the same edge: clear wins.
  - clr does not affect level_out, rise_out or fall_out.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.
- Reset mid-debounce: partial count is discarded; after release the channel requalifies from level=0.
  - An inverted channel whose pin idles at its inactive level sees inv=0, so it produces no spurious edge after reset.
- No wrap-around: cnt never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Package elbert_pkg:
  - clog2 constant function.
  - CLK_HZ = 12_000_000.
  - DEFAULT_DEBOUNCE_CYCLES.
- Sub-module elbert_debounce_ch:
  - Single channel: sync flops, counter, level/rise/fall/toggle registers.
  - Parameter DEBOUNCE_CYCLES; INVERT applied by the parent.
  - Instantiated WIDTH times in a generate loop.

Test Plan (WIDTH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b0011, tick=1 unless stated):
- Reset then idle, raw_in=4'b0011: all outputs 0 for 20 cycles, no pulses.
- raw_in[2] 0->1 held: level_out[2]=1 and rise_out[2]=1 for exactly one cycle at edge 6; toggle_out[2]=1 on that edge; fall_out stays 0.
- raw_in[0] 1->0 (active-low press), held 3 cycles after sync, then back to 1: no change on channel 0. Held 5 cycles: level_out[0]=1, rise_out[0] pulse.
- tick high 1 cycle in 4, raw_in[3] 0->1 held: level_out[3] rises only after the 4th tick with mismatch, about 2+13 cycles. Level never changes on a tick=0 cycle.
- Second press on channel 2: toggle_out[2] returns to 0. Assert toggle_clr[2] on the rise edge of a third press: toggle_out[2]=0, rise_out[2]=1.
- rst_n=0 for 1 cycle while channel 1 has cnt=2: all outputs 0. After release, channel 1 needs the full 4 qualifying ticks.
